// File: rtl/lut_loader_if.sv
// LUT loader bus bundle: byte stream in, async LUT port out, status.
// The loader takes the slave view; the driving environment takes the master view.
interface lut_loader_if;
  logic        START;
  logic        IN_VALID;
  logic [7:0]  IN_BYTE;
  logic        IN_READY;
  logic [11:0] LUT_ADDR;
  logic [7:0]  LUT_WDATA;
  logic        LUT_N_WE;
  logic        LUT_N_OE;
  logic [7:0]  LUT_RDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] CHECKSUM;

  modport slave (
    input  START,
    input  IN_VALID,
    input  IN_BYTE,
    input  LUT_RDATA,
    output IN_READY,
    output LUT_ADDR,
    output LUT_WDATA,
    output LUT_N_WE,
    output LUT_N_OE,
    output BUSY,
    output DONE,
    output ERR,
    output CHECKSUM
  );

  modport master (
    output START,
    output IN_VALID,
    output IN_BYTE,
    output LUT_RDATA,
    input  IN_READY,
    input  LUT_ADDR,
    input  LUT_WDATA,
    input  LUT_N_WE,
    input  LUT_N_OE,
    input  BUSY,
    input  DONE,
    input  ERR,
    input  CHECKSUM
  );
endinterface

// File: rtl/lut_loader.sv
// Streams 4096 bytes into an async 4096x8 LUT with timed write strobes,
// then optionally reads the LUT back and compares a 16-bit checksum.
module lut_loader #(
  parameter int WE_PULSE = 2,
  parameter int VERIFY   = 1
) (
  input  logic        CLK,
  input  logic        RST,
  lut_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    PULSE,
    HOLD,
    RB_ADDR,
    RB_SAMPLE,
    FINISH
  } state_t;

  localparam logic [3:0]  LP_CNT0 = 4'(WE_PULSE - 1);
  localparam logic [11:0] LP_LAST = 12'hFFF;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [11:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_n_we;
  logic        r_n_oe;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_csum;
  logic [15:0] r_rb_sum;

  logic        w_xfer;
  logic        w_last;
  logic [15:0] w_rb_next;

  assign w_xfer    = bus.IN_VALID & r_ready;
  assign w_last    = (r_addr == LP_LAST);
  assign w_rb_next = r_rb_sum + {8'h00, bus.LUT_RDATA};

  // Every strobe and status bit is a register, so N_WE and N_OE only
  // change on state entry and can never overlap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_n_we   <= 1'b1;
      r_n_oe   <= 1'b1;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_csum   <= '0;
      r_rb_sum <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.START) begin
            r_addr  <= '0;
            r_csum  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (w_xfer) begin
            r_wdata <= bus.IN_BYTE;
            r_csum  <= r_csum + {8'h00, bus.IN_BYTE};
            r_ready <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_n_we  <= 1'b0;
          r_cnt   <= LP_CNT0;
          r_state <= PULSE;
        end
        PULSE: begin
          if (r_cnt == 4'd0) begin
            r_n_we  <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (!w_last) begin
            r_addr  <= r_addr + 12'd1;
            r_ready <= 1'b1;
            r_state <= WAIT_DATA;
          end else if (VERIFY != 0) begin
            r_addr   <= '0;
            r_n_oe   <= 1'b0;
            r_rb_sum <= '0;
            r_state  <= RB_ADDR;
          end else begin
            r_n_oe  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        RB_ADDR: begin
          r_state <= RB_SAMPLE;
        end
        RB_SAMPLE: begin
          r_rb_sum <= w_rb_next;
          if (!w_last) begin
            r_addr  <= r_addr + 12'd1;
            r_state <= RB_ADDR;
          end else begin
            r_err   <= (w_rb_next != r_csum);
            r_n_oe  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.IN_READY  = r_ready;
  assign bus.LUT_ADDR  = r_addr;
  assign bus.LUT_WDATA = r_wdata;
  assign bus.LUT_N_WE  = r_n_we;
  assign bus.LUT_N_OE  = r_n_oe;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.ERR       = r_err;
  assign bus.CHECKSUM  = r_csum;

endmodule

// File: tb/tb_lut_loader.sv
// Scoreboard bench for lut_loader: two instances (verify and no-verify)
// share one behavioural LUT model; one is active at a time.
module tb_lut_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] in_byte;
  logic       sel;
  logic       force100;
  logic       mon_clr;
  int         cur_pw;

  int n_vec  = 0;
  int n_fail = 0;
  int n_ov;
  int n_pw;
  int n_stab;
  int n_noe;

  logic [7:0]  mem [4096];
  logic [19:0] sbq [$];

  always #5 clk = ~clk;

  lut_loader_if ifa ();
  lut_loader_if ifb ();

  lut_loader #(.WE_PULSE(2), .VERIFY(1)) u_a (
    .CLK (clk),
    .RST (rst),
    .bus (ifa.slave)
  );

  lut_loader #(.WE_PULSE(1), .VERIFY(0)) u_b (
    .CLK (clk),
    .RST (rst),
    .bus (ifb.slave)
  );

  assign ifa.START    = start & ~sel;
  assign ifb.START    = start & sel;
  assign ifa.IN_VALID = valid & ~sel;
  assign ifb.IN_VALID = valid & sel;
  assign ifa.IN_BYTE  = in_byte;
  assign ifb.IN_BYTE  = in_byte;
  assign ifa.LUT_RDATA =
    (force100 && ifa.LUT_ADDR == 12'd100) ? 8'h00 : mem[ifa.LUT_ADDR];
  assign ifb.LUT_RDATA = mem[ifb.LUT_ADDR];

  logic        m_nwe, m_noe, m_ready, m_busy, m_done, m_err;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata;
  logic [15:0] m_csum;

  assign m_nwe   = sel ? ifb.LUT_N_WE  : ifa.LUT_N_WE;
  assign m_noe   = sel ? ifb.LUT_N_OE  : ifa.LUT_N_OE;
  assign m_ready = sel ? ifb.IN_READY  : ifa.IN_READY;
  assign m_busy  = sel ? ifb.BUSY      : ifa.BUSY;
  assign m_done  = sel ? ifb.DONE      : ifa.DONE;
  assign m_err   = sel ? ifb.ERR       : ifa.ERR;
  assign m_addr  = sel ? ifb.LUT_ADDR  : ifa.LUT_ADDR;
  assign m_wdata = sel ? ifb.LUT_WDATA : ifa.LUT_WDATA;
  assign m_csum  = sel ? ifb.CHECKSUM  : ifa.CHECKSUM;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle observer: commits writes to the LUT model on falling N_WE,
  // pops the scoreboard, and counts strobe/stability violations.
  task automatic monitor();
    logic        pwe;
    int          lowcnt;
    logic [11:0] pa, la;
    logic [7:0]  pd, ld;
    logic [19:0] e;
    pwe = 1'b1; lowcnt = 0;
    pa = '0; pd = '0; la = '0; ld = '0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        n_ov = 0; n_pw = 0; n_stab = 0; n_noe = 0;
        pwe = 1'b1; lowcnt = 0;
      end else begin
        if (!m_nwe && !m_noe) n_ov++;
        if (!m_noe) n_noe++;
        if (pwe && !m_nwe) begin
          if (m_addr !== pa || m_wdata !== pd) n_stab++;
          la = m_addr; ld = m_wdata;
          mem[m_addr] = m_wdata;
          chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("write", {12'h0, m_addr, m_wdata}, {12'h0, e});
          end
          lowcnt = 1;
        end else if (!m_nwe) begin
          lowcnt++;
          if (m_addr !== la || m_wdata !== ld) n_stab++;
        end else if (!pwe) begin
          if (lowcnt != cur_pw) n_pw++;
          if (m_busy && (m_addr !== la || m_wdata !== ld)) n_stab++;
        end
        pwe = m_nwe; pa = m_addr; pd = m_wdata;
      end
    end
  endtask

  task automatic clr_mon();
    @(posedge clk); #1;
    mon_clr = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  function automatic int mem_mism();
    int n;
    logic [7:0] b;
    n = 0;
    for (int i = 0; i < 4096; i++) begin
      b = 8'(i * 7);
      if (mem[i] !== b) n++;
    end
    return n;
  endfunction

  // Drive one load; cyc counts edges after the START-sampling edge.
  task automatic run_load(input int low_pct, input int abort_addr,
                          input int restart_at, output int cyc,
                          output logic [15:0] csum);
    int idx;
    int lows;
    logic v;
    idx = 0; lows = 0; csum = '0; cyc = 0;
    @(negedge clk);
    start = 1'b1;
    forever begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (m_done) break;
      if (cyc > 60000) begin
        chk("load_timeout", 32'(m_done), 32'd1);
        break;
      end
      if (abort_addr >= 0 && m_addr == 12'(abort_addr) && !m_nwe) begin
        lows++;
        if (lows == 2) begin
          valid = 1'b0;
          rst = 1'b1;
          @(posedge clk); #1;
          chk("rst_n_we", 32'(m_nwe), 32'd1);
          chk("rst_busy", 32'(m_busy), 32'd0);
          chk("rst_done", 32'(m_done), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          break;
        end
      end
      v = (idx < 4096) && (int'($urandom_range(99)) >= low_pct);
      valid = v;
      in_byte = 8'(idx * 7);
      if (v && m_ready) begin
        sbq.push_back({12'(idx), 8'(idx * 7)});
        csum = csum + {8'h00, 8'(idx * 7)};
        idx++;
      end
      cyc++;
    end
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic post_checks(input int exp_noe);
    chk("we_oe_overlap", 32'(n_ov), 32'd0);
    chk("we_pulse_width", 32'(n_pw), 32'd0);
    chk("addr_data_stable", 32'(n_stab), 32'd0);
    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    chk("lut_contents", 32'(mem_mism()), 32'd0);
    chk("n_oe_low_cycles", 32'(n_noe), 32'(exp_noe));
  endtask

  initial begin
    int cyc;
    logic [15:0] cs;
    rst = 1'b1; start = 1'b0; valid = 1'b0; in_byte = '0;
    sel = 1'b0; force100 = 1'b0; mon_clr = 1'b0; cur_pw = 2;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_n_we", 32'(ifa.LUT_N_WE), 32'd1);
    chk("rst_n_oe", 32'(ifa.LUT_N_OE), 32'd1);
    chk("rst_ready", 32'(ifa.IN_READY), 32'd0);
    chk("rst_busy", 32'(ifa.BUSY), 32'd0);
    chk("rst_done", 32'(ifa.DONE), 32'd0);
    chk("rst_err", 32'(ifa.ERR), 32'd0);
    chk("rst_addr", 32'(ifa.LUT_ADDR), 32'd0);
    chk("rst_wdata", 32'(ifa.LUT_WDATA), 32'd0);
    chk("rst_csum", 32'(ifa.CHECKSUM), 32'd0);
    rst = 1'b0;

    // full-rate verified load
    clr_mon();
    run_load(0, -1, -1, cyc, cs);
    chk("s1_cycles", 32'(cyc), 32'(4096 * 5 + 8192));
    chk("s1_done", 32'(m_done), 32'd1);
    chk("s1_busy", 32'(m_busy), 32'd0);
    chk("s1_err", 32'(m_err), 32'd0);
    chk("s1_csum", 32'(m_csum), 32'(cs));
    post_checks(8192);
    repeat (5) @(negedge clk);
    chk("idle_hold_done", 32'(m_done), 32'd1);
    chk("idle_hold_csum", 32'(m_csum), 32'(cs));
    chk("idle_hold_err", 32'(m_err), 32'd0);

    // reset mid-pulse at address 10
    clr_mon();
    run_load(0, 10, -1, cyc, cs);
    chk("abort_sb_leftover", 32'(sbq.size()), 32'd0);

    // fresh starved load, location 100 reads back wrong
    clr_mon();
    force100 = 1'b1;
    run_load(30, -1, -1, cyc, cs);
    chk("s2_done", 32'(m_done), 32'd1);
    chk("s2_err", 32'(m_err), 32'd1);
    chk("s2_csum", 32'(m_csum), 32'(cs));
    post_checks(8192);
    force100 = 1'b0;

    // no-verify instance, START re-pulsed mid-load
    sel = 1'b1;
    cur_pw = 1;
    clr_mon();
    run_load(0, -1, 5000, cyc, cs);
    chk("s5_cycles", 32'(cyc), 32'(4096 * 4));
    chk("s5_done", 32'(m_done), 32'd1);
    chk("s5_err", 32'(m_err), 32'd0);
    chk("s5_csum", 32'(m_csum), 32'(cs));
    post_checks(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_loader.md
LUT_LOADER -- requirements
Module: lut_loader

Interface
REQ-001 SHALL have parameter WE_PULSE, default 2: cycles LUT_N_WE is held low per write, legal range 1..15.
REQ-002 SHALL have parameter VERIFY, default 1: 1 = read back and checksum after load, 0 = skip readback.
REQ-003 SHALL have ports: CLK  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: START  in  1  begin a load; sampled only in IDLE.
REQ-006 SHALL have ports: IN_VALID  in  1 / IN_BYTE  in  8 / IN_READY  out  1  byte stream, transfer when IN_VALID && IN_READY.
REQ-007 SHALL have ports: LUT_ADDR  out  12 / LUT_WDATA  out  8 / LUT_N_WE  out  1 / LUT_N_OE  out  1 / LUT_RDATA  in  8  4096x8 async LUT port, write committed on falling LUT_N_WE.
REQ-008 SHALL have ports: BUSY  out  1 / DONE  out  1 / ERR  out  1 / CHECKSUM  out  16  status.

Function
REQ-009 SHALL drive every output from a register; no combinational input-to-output path.
REQ-010 SHALL implement states IDLE, WAIT_DATA, SETUP, PULSE, HOLD, RB_ADDR, RB_SAMPLE and FINISH.
REQ-011 SHALL, in IDLE with START=1, clear LUT_ADDR, CHECKSUM and ERR, clear DONE, set BUSY, and enter WAIT_DATA next cycle.
REQ-012 SHALL assert IN_READY only in WAIT_DATA; on a transfer it SHALL latch IN_BYTE into LUT_WDATA, add it zero-extended to CHECKSUM mod 2^16, and enter SETUP.
REQ-013 SHALL hold LUT_N_WE high in SETUP for exactly 1 cycle with LUT_ADDR and LUT_WDATA already stable.
REQ-014 SHALL hold LUT_N_WE low for exactly WE_PULSE cycles in PULSE.
REQ-015 SHALL hold LUT_N_WE high for 1 cycle in HOLD with LUT_ADDR and LUT_WDATA unchanged.
REQ-016 SHALL, after HOLD, go to WAIT_DATA with LUT_ADDR+1 if LUT_ADDR!=4095; at 4095 it SHALL go to RB_ADDR if VERIFY=1, else FINISH.
REQ-017 SHALL keep LUT_ADDR and LUT_WDATA constant from SETUP entry to HOLD exit, so each write uses a single address and a single data value.
REQ-018 SHALL keep LUT_N_OE high in every state except RB_ADDR and RB_SAMPLE.
REQ-019 SHALL never have LUT_N_WE and LUT_N_OE low in the same cycle, including across state and reset transitions.
REQ-020 SHALL, on RB_ADDR entry, set LUT_ADDR to 0, drive LUT_N_OE low, and initialise a 16-bit readback sum to 0.
REQ-021 SHALL spend 1 RB_ADDR cycle per address as settle time, then 1 RB_SAMPLE cycle that adds LUT_RDATA to the readback sum.
REQ-022 SHALL, after RB_SAMPLE, go to RB_ADDR with LUT_ADDR+1 if LUT_ADDR!=4095, else go to FINISH.
REQ-023 SHALL, on FINISH entry from readback, set ERR=1 iff the readback sum (including the final sample) != CHECKSUM.
REQ-024 SHALL, in FINISH, set LUT_N_OE high, BUSY=0 and DONE=1, then enter IDLE next cycle.
REQ-025 SHALL hold DONE, ERR and CHECKSUM in IDLE until the next accepted START.
REQ-026 SHALL ignore START outside IDLE.
REQ-027 SHALL hold state indefinitely in WAIT_DATA while IN_VALID=0, with LUT_N_WE high.
REQ-028 SHALL make total load time with IN_VALID always 1 equal to 4096*(WE_PULSE+3) cycles, plus 8192 cycles readback if VERIFY=1.

Reset
REQ-029 SHALL, one edge after RST=1, be in IDLE with LUT_N_WE=1, LUT_N_OE=1, IN_READY=0, BUSY=0, DONE=0, ERR=0, LUT_ADDR=0, LUT_WDATA=0, CHECKSUM=0.
REQ-030 SHALL give RST priority over all state transitions, including mid-PULSE, which releases LUT_N_WE high on that same edge.
REQ-031 SHALL treat a partial load aborted by RST as abandoned; DONE is not asserted for it.

Verification
REQ-032 Bench SHALL cover: WE_PULSE=2, VERIFY=1, stream byte (i*7)&0xFF for i=0..4095 against an LUT model -> every model location matches, CHECKSUM = sum mod 2^16, ERR=0, DONE=1 at cycle 4096*5+8192+~3.
REQ-033 Bench SHALL cover: same load with the model forcing location 100 to read 0x00 instead of 0xBC -> ERR=1, DONE=1.
REQ-034 Bench SHALL cover: IN_VALID toggled randomly at 30% -> identical memory contents, LUT_N_WE low only inside PULSE, no writes while starved.
REQ-035 Bench SHALL cover: RST raised on the 2nd PULSE cycle at addr 10 -> next cycle LUT_N_WE=1, BUSY=0, DONE=0; a fresh START then loads all 4096 bytes correctly.
REQ-036 Bench SHALL cover: START pulsed again mid-load, with VERIFY=0 and WE_PULSE=1 -> no restart, 4096*4 cycle load, LUT_N_OE stays 1 throughout.
REQ-037 Bench SHALL cover: every cycle of every scenario -> !(LUT_N_WE==0 && LUT_N_OE==0), and LUT_ADDR/LUT_WDATA stable from SETUP to HOLD.
